// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program-counter sequencer: next-pc source encoding,
// the counter width, and the priority selector used by the pc mux.
package pc_sequencer_pkg;

  localparam int unsigned PC_SRC_W           = 3;
  localparam int unsigned BRANCH_COUNT_WIDTH = 16;

  localparam logic [PC_SRC_W-1:0] PC_SRC_INC = 3'd0;
  localparam logic [PC_SRC_W-1:0] PC_SRC_IMM = 3'd1;
  localparam logic [PC_SRC_W-1:0] PC_SRC_IND = 3'd2;
  localparam logic [PC_SRC_W-1:0] PC_SRC_RET = 3'd3;
  localparam logic [PC_SRC_W-1:0] PC_SRC_INT = 3'd4;

  // Single winner per cycle: interrupt > return > indirect > immediate > increment.
  function automatic logic [PC_SRC_W-1:0] select_pc_src(
    input logic interrupt_take,
    input logic ret,
    input logic jump,
    input logic jump_immediate
  );
    if (interrupt_take)      return PC_SRC_INT;
    else if (ret)            return PC_SRC_RET;
    else if (jump)           return PC_SRC_IND;
    else if (jump_immediate) return PC_SRC_IMM;
    else                     return PC_SRC_INC;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode-side control strobes and targets into the sequencer, and the pc /
// call-stack status it returns toward fetch.
interface pc_sequencer_if
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned PROGRAM_ADDR_WIDTH = 32,
  parameter int unsigned CALL_STACK_DEPTH   = 8
);

  logic                              stall;
  logic                              jump_immediate;
  logic                              branch;
  logic                              call;
  logic                              jump;
  logic                              ret;
  logic                              interrupt_take;
  logic [PROGRAM_ADDR_WIDTH-1:0]     immediate_address;
  logic [PROGRAM_ADDR_WIDTH-1:0]     jump_address;
  logic [PROGRAM_ADDR_WIDTH-1:0]     interrupt_vector;

  logic [PROGRAM_ADDR_WIDTH-1:0]     pc;
  logic [PROGRAM_ADDR_WIDTH-1:0]     return_address;
  logic [$clog2(CALL_STACK_DEPTH):0] call_depth;
  logic                              stack_overflow;
  logic                              stack_underflow;
  logic [BRANCH_COUNT_WIDTH-1:0]     branches_taken;

  modport master (
    output stall, jump_immediate, branch, call, jump, ret, interrupt_take,
           immediate_address, jump_address, interrupt_vector,
    input  pc, return_address, call_depth, stack_overflow, stack_underflow,
           branches_taken
  );

  modport slave (
    input  stall, jump_immediate, branch, call, jump, ret, interrupt_take,
           immediate_address, jump_address, interrupt_vector,
    output pc, return_address, call_depth, stack_overflow, stack_underflow,
           branches_taken
  );

endinterface

// File: rtl/pc_sequencer_call_stack.sv
// Circular return-address stack: pushes past full overwrite the oldest entry,
// pops on empty are refused; both events latch a sticky flag until reset.
module pc_sequencer_call_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        push_data,
  output logic [WIDTH-1:0]        top,
  output logic [$clog2(DEPTH):0]  depth,
  output logic                    empty,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned DEPTH_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   ptr_prev;
  logic [DEPTH_W-1:0] depth_q;
  logic               overflow_q;
  logic               underflow_q;
  logic               full;

  assign ptr_prev = ptr - PTR_W'(1);
  assign full     = (depth_q == DEPTH_W'(DEPTH));
  assign empty    = (depth_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr         <= '0;
      depth_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PTR_W'(1);
      if (full) overflow_q <= 1'b1;
      else      depth_q    <= depth_q + DEPTH_W'(1);
    end else if (pop) begin
      if (empty) begin
        underflow_q <= 1'b1;
      end else begin
        ptr     <= ptr_prev;
        depth_q <= depth_q - DEPTH_W'(1);
      end
    end
  end

  // Entry storage carries no reset; stale contents are masked by depth.
  always_ff @(posedge clk) begin
    if (push) mem[ptr] <= push_data;
  end

  assign top       = empty ? '0 : mem[ptr_prev];
  assign depth     = depth_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: picks one control-flow action per cycle, drives
// the registered pc toward fetch and owns the hardware call stack.
module pc_sequencer #(
  parameter int unsigned                   PROGRAM_ADDR_WIDTH = 32,
  parameter int unsigned                   CALL_STACK_DEPTH   = 8,
  parameter logic [PROGRAM_ADDR_WIDTH-1:0] RESET_PC           = '0
) (
  input  logic           clk,
  input  logic           reset,
  pc_sequencer_if.slave  bus
);

  import pc_sequencer_pkg::*;

  localparam int unsigned AW = PROGRAM_ADDR_WIDTH;

  logic [AW-1:0]                 pc_q;
  logic [AW-1:0]                 pc_inc;
  logic [AW-1:0]                 pc_next;
  logic [PC_SRC_W-1:0]           pc_src;
  logic                          push;
  logic                          pop;
  logic [AW-1:0]                 push_data;
  logic                          advance;
  logic [AW-1:0]                 stack_top;
  logic [$clog2(CALL_STACK_DEPTH):0] stack_depth;
  logic                          stack_empty;
  logic                          stack_overflow;
  logic                          stack_underflow;
  logic [BRANCH_COUNT_WIDTH-1:0] branches_q;

  assign pc_inc  = pc_q + AW'(1);
  assign advance = ~reset & ~bus.stall;

  // Next-pc mux and stack request for the winning action.
  always_comb begin
    pc_src    = select_pc_src(bus.interrupt_take, bus.ret, bus.jump, bus.jump_immediate);
    pc_next   = pc_inc;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_inc;
    case (pc_src)
      PC_SRC_INT: begin
        push      = 1'b1;
        push_data = pc_q;
        pc_next   = bus.interrupt_vector;
      end
      PC_SRC_RET: begin
        pop     = 1'b1;
        pc_next = stack_empty ? pc_inc : stack_top;
      end
      PC_SRC_IND: pc_next = bus.jump_address;
      PC_SRC_IMM: begin
        push    = bus.call;
        pc_next = bus.immediate_address;
      end
      default: pc_next = pc_inc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      branches_q <= '0;
    end else if (!bus.stall) begin
      pc_q <= pc_next;
      // Counted on every taken branch, even when a higher-priority action wins.
      if (bus.branch && bus.jump_immediate) branches_q <= branches_q + BRANCH_COUNT_WIDTH'(1);
    end
  end

  pc_sequencer_call_stack #(
    .WIDTH (AW),
    .DEPTH (CALL_STACK_DEPTH)
  ) u_call_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push & advance),
    .pop       (pop & advance),
    .push_data (push_data),
    .top       (stack_top),
    .depth     (stack_depth),
    .empty     (stack_empty),
    .overflow  (stack_overflow),
    .underflow (stack_underflow)
  );

  assign bus.pc              = pc_q;
  assign bus.return_address  = stack_top;
  assign bus.call_depth      = stack_depth;
  assign bus.stack_overflow  = stack_overflow;
  assign bus.stack_underflow = stack_underflow;
  assign bus.branches_taken  = branches_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: hand-computed pc / stack / counter values
// for reset, calls, overflow, underflow, interrupt priority, stall and wrap.
module tb_pc_sequencer;

  localparam int unsigned AW    = 32;
  localparam int unsigned DEPTH = 8;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  pc_sequencer_if #(.PROGRAM_ADDR_WIDTH(AW), .CALL_STACK_DEPTH(DEPTH)) bus ();

  pc_sequencer #(
    .PROGRAM_ADDR_WIDTH (AW),
    .CALL_STACK_DEPTH   (DEPTH),
    .RESET_PC           ('0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.stall             = 1'b0;
    bus.jump_immediate    = 1'b0;
    bus.branch            = 1'b0;
    bus.call              = 1'b0;
    bus.jump              = 1'b0;
    bus.ret               = 1'b0;
    bus.interrupt_take    = 1'b0;
    bus.immediate_address = '0;
    bus.jump_address      = '0;
    bus.interrupt_vector  = '0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    check("reset_pc", bus.pc, 32'h0);
    check("reset_depth", 32'(bus.call_depth), 32'd0);
    check("reset_ovf", 32'(bus.stack_overflow), 32'd0);
    check("reset_unf", 32'(bus.stack_underflow), 32'd0);
    check("reset_br", 32'(bus.branches_taken), 32'd0);
    check("reset_top", bus.return_address, 32'h0);

    // Idle increment
    reset = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("idle_pc", bus.pc, 32'(i));
    end
    check("idle_depth", 32'(bus.call_depth), 32'd0);

    // Call at pc 5, then return
    bus.call = 1'b1; bus.jump_immediate = 1'b1; bus.immediate_address = 32'h40;
    tick();
    check("call_pc", bus.pc, 32'h40);
    check("call_top", bus.return_address, 32'h6);
    check("call_depth", 32'(bus.call_depth), 32'd1);
    clear_inputs();
    bus.ret = 1'b1;
    tick();
    check("ret_pc", bus.pc, 32'h6);
    check("ret_depth", 32'(bus.call_depth), 32'd0);
    check("ret_top_empty", bus.return_address, 32'h0);

    // Nine nested calls overflow an 8-entry stack
    clear_inputs();
    bus.call = 1'b1; bus.jump_immediate = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      bus.immediate_address = 32'(k * 256);
      tick();
      check("nest_pc", bus.pc, 32'(k * 256));
      check("nest_depth", 32'(bus.call_depth), (k > 8) ? 32'd8 : 32'(k));
      check("nest_ovf", 32'(bus.stack_overflow), (k == 9) ? 32'd1 : 32'd0);
    end
    check("nest_top", bus.return_address, 32'h801);

    // Eight returns unwind calls 9..2; call 1's return address was overwritten
    clear_inputs();
    bus.ret = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      tick();
      check("unwind_pc", bus.pc, 32'((9 - j) * 256 + 1));
      check("unwind_depth", 32'(bus.call_depth), 32'(8 - j));
      check("unwind_unf", 32'(bus.stack_underflow), 32'd0);
    end
    tick();
    check("underflow_pc", bus.pc, 32'h102);
    check("underflow_flag", 32'(bus.stack_underflow), 32'd1);
    check("underflow_depth", 32'(bus.call_depth), 32'd0);

    // Indirect jump to 0x10, then interrupt beats a simultaneous ret
    clear_inputs();
    bus.jump = 1'b1; bus.jump_address = 32'h10;
    tick();
    check("ind_pc", bus.pc, 32'h10);
    clear_inputs();
    bus.interrupt_take = 1'b1; bus.ret = 1'b1; bus.interrupt_vector = 32'h100;
    tick();
    check("int_pc", bus.pc, 32'h100);
    check("int_depth", 32'(bus.call_depth), 32'd1);
    check("int_top", bus.return_address, 32'h10);

    // Stall holds everything including the branch counter
    clear_inputs();
    bus.stall = 1'b1; bus.jump_immediate = 1'b1; bus.branch = 1'b1;
    bus.immediate_address = 32'h300;
    for (int s = 0; s < 4; s++) begin
      tick();
      check("stall_pc", bus.pc, 32'h100);
      check("stall_depth", 32'(bus.call_depth), 32'd1);
      check("stall_br", 32'(bus.branches_taken), 32'd0);
    end
    bus.stall = 1'b0;
    tick();
    check("unstall_pc", bus.pc, 32'h300);
    check("unstall_br", 32'(bus.branches_taken), 32'd1);
    check("sticky_ovf", 32'(bus.stack_overflow), 32'd1);

    // Three taken branches, then two not taken
    for (int b = 0; b < 3; b++) begin
      bus.immediate_address = 32'(32'h400 + b * 16);
      tick();
      check("taken_pc", bus.pc, 32'(32'h400 + b * 16));
      check("taken_br", 32'(bus.branches_taken), 32'(2 + b));
    end
    bus.jump_immediate = 1'b0;
    tick();
    check("nt_pc0", bus.pc, 32'h421);
    tick();
    check("nt_pc1", bus.pc, 32'h422);
    check("nt_br", 32'(bus.branches_taken), 32'd4);

    // Taken branch still counted when an indirect jump wins
    bus.jump_immediate = 1'b1; bus.jump = 1'b1; bus.jump_address = 32'h500;
    tick();
    check("win_pc", bus.pc, 32'h500);
    check("win_br", 32'(bus.branches_taken), 32'd5);
    check("win_depth", 32'(bus.call_depth), 32'd1);

    // Call without jump_immediate is a plain increment
    clear_inputs();
    bus.call = 1'b1;
    tick();
    check("call_noji_pc", bus.pc, 32'h501);
    check("call_noji_depth", 32'(bus.call_depth), 32'd1);

    // pc wraps at the top of the address space
    clear_inputs();
    bus.jump = 1'b1; bus.jump_address = 32'hFFFF_FFFF;
    tick();
    check("wrap_pre", bus.pc, 32'hFFFF_FFFF);
    clear_inputs();
    tick();
    check("wrap_pc", bus.pc, 32'h0);

    // Reset with the stack partly full, then a ret underflows
    reset = 1'b1;
    tick();
    check("rst2_pc", bus.pc, 32'h0);
    check("rst2_depth", 32'(bus.call_depth), 32'd0);
    check("rst2_ovf", 32'(bus.stack_overflow), 32'd0);
    check("rst2_unf", 32'(bus.stack_underflow), 32'd0);
    check("rst2_br", 32'(bus.branches_taken), 32'd0);
    reset = 1'b0;
    bus.ret = 1'b1;
    tick();
    check("rst2_ret_pc", bus.pc, 32'h1);
    check("rst2_ret_unf", 32'(bus.stack_underflow), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Consumer of the jump/branch decision. Takes `jump_immediate`/`branch` from the jump-immediate control block, the decoded call/return/indirect-jump strobes and the interrupt request, and produces the registered program counter.
- Owns the hardware call stack: a circular buffer of return addresses, with depth tracking and sticky overflow/underflow flags.
- Sits between decode and instruction fetch. `pc` drives the instruction memory address.

Parameters:
- PROGRAM_ADDR_WIDTH, 32, width of pc and all address ports.
- CALL_STACK_DEPTH, 8, number of return-address entries; must be a power of 2, at least 2.
- RESET_PC, 0, pc value after reset.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold all state this cycle.
- jump_immediate  input  1  taken decision from jump-immediate control.
- branch  input  1  instruction is a conditional branch; used only for statistics.
- call  input  1  decoded CALLI; pushes when `jump_immediate`=1.
- jump  input  1  indirect jump to `jump_address`.
- ret  input  1  return: pop the stack into pc.
- interrupt_take  input  1  vector to `interrupt_vector`, pushing the current pc.
- immediate_address  input  PROGRAM_ADDR_WIDTH  target for immediate jumps.
- jump_address  input  PROGRAM_ADDR_WIDTH  target for indirect jumps.
- interrupt_vector  input  PROGRAM_ADDR_WIDTH  interrupt handler address.
- pc  output  PROGRAM_ADDR_WIDTH  current program counter (registered).
- return_address  output  PROGRAM_ADDR_WIDTH  top-of-stack entry; 0 when empty.
- call_depth  output  $clog2(CALL_STACK_DEPTH)+1  number of valid entries.
- stack_overflow  output  1  sticky; a push occurred while full.
- stack_underflow  output  1  sticky; a pop occurred while empty.
- branches_taken  output  16  count of cycles with `branch` & `jump_immediate`; wraps.

Behaviour:
- Reset (sync, highest priority):
  - pc = RESET_PC; call_depth = 0; stack pointer = 0.
  - Both sticky flags = 0; branches_taken = 0; return_address = 0.
  - Stack RAM contents are don't-care.
- Stall (when not in reset): pc, stack, pointer, depth, flags and counter all hold. All other inputs are ignored.
- Otherwise exactly one action per cycle, in this priority order:
  1. `interrupt_take`: push pc; pc <= interrupt_vector. The interrupted instruction re-executes on return.
  2. `ret`: pop; pc <= top entry.
  3. `jump`: pc <= jump_address. No stack change.
  4. `jump_immediate` & `call`: push pc+1; pc <= immediate_address.
  5. `jump_immediate` alone: pc <= immediate_address.
  6. Default: pc <= pc+1, wrapping modulo 2^PROGRAM_ADDR_WIDTH.
- Lower-priority strobes asserted in the same cycle are ignored. They are not deferred.
- `call` without `jump_immediate` behaves as default increment with no push.
- Latency: all outputs are registered. The decision sampled at edge N is visible on pc after edge N.
- Push:
  - Write to entry[ptr]; ptr <= ptr+1 mod DEPTH.
  - depth <= min(depth+1, DEPTH).
  - Push at depth==DEPTH overwrites the oldest entry (circular) and sets stack_overflow. Depth stays DEPTH.
- Pop:
  - ptr <= ptr-1 mod DEPTH; depth <= depth-1.
  - Pop at depth==0: pc <= pc+1, stack_underflow set, ptr and depth unchanged.
- return_address = entry[ptr-1] when depth>0, else 0. It is combinational from registered state.
- branches_taken increments on non-stalled cycles with `branch`=1 and `jump_immediate`=1, including cycles where a higher-priority action wins. It wraps from 0xFFFF to 0.
- Sticky flags clear only on reset.
- Reset asserted mid-sequence with the stack partly full: next cycle pc = RESET_PC and depth = 0. A following ret underflows.

Decomposition:
- Shared package/header gets the priority-select encoding (PC_SRC_INC, PC_SRC_IMM, PC_SRC_IND, PC_SRC_RET, PC_SRC_INT) as localparam constants, alongside the existing instruction defines.
- One sub-module is natural: `call_stack`, the circular buffer with push/pop/depth/overflow/underflow and top output, parameterised by width and depth.
- The pc mux and counter stay in pc_sequencer.

Test Plan:
- Reset, then 3 idle cycles -> pc goes 0, 1, 2, 3; call_depth=0; both flags 0.
- At pc=5, call=1 with jump_immediate=1 and immediate_address=0x40 -> pc=0x40, return_address=6, depth=1. Then ret -> pc=6, depth=0.
- 9 calls at DEPTH=8 -> stack_overflow=1, depth=8. Then 8 rets -> pcs are the returns of calls 9..2; the entry for call 1 is lost. A 9th ret -> stack_underflow=1, pc increments.
- At pc=0x10, interrupt_take and ret both high with vector 0x100 -> pc=0x100, depth+1, top=0x10. The ret is ignored.
- stall held 4 cycles during jump_immediate=1 -> pc and depth unchanged; branches_taken unchanged. Release -> jump occurs.
- 3 taken branches, then 2 not-taken (branch=1, jump_immediate=0) -> branches_taken=3; not-taken cycles increment pc.
